// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and architectural register indices.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [DATA_W-1:0] SP_INIT_DEFAULT = 32'd227;

endpackage

// File: rtl/banco_reg_rdport.sv
// Combinational register-file read port: $zero forcing, optional write bypass, array mux.
module banco_reg_rdport
  import mips_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [DATA_W-1:0]               rd_data
);

  // Matching a non-zero rd_addr already implies wr_addr != 0, so $zero writes never bypass.
  always_comb begin
    rd_data = '0;
    if (rd_addr == REG_ZERO) begin
      rd_data = '0;
    end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule

// File: rtl/banco_reg.sv
// MIPS multicycle register bank: 32 GPRs with two operand ports and a debug port, HI/LO pair,
// and a committed-write counter.
module banco_reg
  import mips_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEFAULT,
  parameter int unsigned       BYPASS  = 0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              HiLoWrite,
  input  logic [DATA_W-1:0] HiIn,
  input  logic [DATA_W-1:0] LoIn,
  output logic [DATA_W-1:0] HiOut,
  output logic [DATA_W-1:0] LoOut,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  WriteCount
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               hi_q, hi_d;
  logic [DATA_W-1:0]               lo_q, lo_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            gpr_commit;

  always_comb begin
    gpr_commit = RegWrite && (WriteReg != REG_ZERO);
    regs_d     = regs_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (gpr_commit) begin
      regs_d[WriteReg] = WriteData;
      cnt_d            = cnt_q + CNT_W'(1);
    end
    if (HiLoWrite) begin
      hi_d = HiIn;
      lo_d = LoIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q         <= '0;
      regs_q[REG_SP] <= SP_INIT;
      hi_q           <= '0;
      lo_q           <= '0;
      cnt_q          <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
    end
  end

  banco_reg_rdport #(.BYPASS(BYPASS != 0)) u_rd1 (
    .regs    (regs_q),
    .wr_en   (RegWrite),
    .wr_addr (WriteReg),
    .wr_data (WriteData),
    .rd_addr (ReadReg1),
    .rd_data (ReadData1)
  );

  banco_reg_rdport #(.BYPASS(BYPASS != 0)) u_rd2 (
    .regs    (regs_q),
    .wr_en   (RegWrite),
    .wr_addr (WriteReg),
    .wr_data (WriteData),
    .rd_addr (ReadReg2),
    .rd_data (ReadData2)
  );

  // Debug view always reflects stored contents only.
  banco_reg_rdport #(.BYPASS(1'b0)) u_dbg (
    .regs    (regs_q),
    .wr_en   (1'b0),
    .wr_addr ('0),
    .wr_data ('0),
    .rd_addr (DbgAddr),
    .rd_data (DbgData)
  );

  assign HiOut      = hi_q;
  assign LoOut      = lo_q;
  assign WriteCount = cnt_q;

endmodule
